mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port to one-port memory arbiter directly downstream of the pipelined LC-3b datapath. It takes the instruction-fetch port (Port A, read-only) and the data port (Port B, read/write) and serialises them onto a single physical memory port. Each requester sees a normal level-held request / single-cycle response handshake. Downstream latency may be arbitrary, and at most one transaction is outstanding at a time.

## Interface
- No parameters. Data width is fixed at 16 bits and address width at 16 bits.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- read_a  in  1  Port A read request, held until resp_a.
- address_a  in  16  Port A word address, stable while read_a is high.
- resp_a  out  1  Port A completion pulse, one cycle.
- rdata_a  out  16  Port A read data, valid when resp_a=1.
- read_b, write_b  in  1 each  Port B request, held until resp_b.
- wmask_b  in  2  Port B byte mask; [1] selects the high byte, [0] the low byte.
- address_b, wdata_b  in  16 each  Port B address and write data, stable while requesting.
- resp_b  out  1  Port B completion pulse, one cycle.
- rdata_b  out  16  Port B read data, valid when resp_b=1.
- pmem_read, pmem_write  out  1 each  physical memory request strobes, held until pmem_resp.
- pmem_wmask  out  2  physical byte mask.
- pmem_address, pmem_wdata  out  16 each  physical address and write data.
- pmem_resp  in  1  physical completion pulse.
- pmem_rdata  in  16  physical read data, valid when pmem_resp=1.

## Operation
- FSM states: IDLE, SERVE_A, SERVE_B.
- IDLE:
  - Sample requests; req_a = read_a and req_b = read_b | write_b.
  - Only A requesting → go to SERVE_A. Only B requesting → go to SERVE_B.
  - Both requesting → winner chosen by the arbitration policy (see Configuration).
  - On the transition edge, capture the winner's address, wdata, wmask and op into registers.
  - Captured op: write if write_b, else read. For Port A, wmask is captured as 2'b11 and wdata as 0.
- SERVE_x:
  - Drive pmem_read or pmem_write from the captured op; pmem_address, pmem_wdata and pmem_wmask come from the captured registers.
  - When pmem_resp=1: resp_x=1 in that same cycle (combinational), rdata_x = pmem_rdata, next state IDLE.
  - The captured op is not re-evaluated while in SERVE_x.
- rdata_a and rdata_b are both driven from pmem_rdata at all times; only the resp pulse qualifies them.
- read_b and write_b both high is illegal. If it occurs, write wins, with no error flag.
- pmem_resp arriving in IDLE is ignored, and no resp_x is generated.
- A requester that drops its request while in SERVE_x does not abort the transaction. The transaction completes, and a resp_x pulse is still issued.
- resp_a and resp_b are never asserted in the same cycle.

## Timing
- Reset values: state=IDLE and all registered outputs = 0. Hence pmem_read=pmem_write=0, pmem_wmask=0, pmem_address=0, pmem_wdata=0, resp_a=resp_b=0.
- Reset asserted mid-transaction forces IDLE immediately; any in-flight pmem_resp is dropped.
- Latency (no contention):
  - Request seen in IDLE at edge N.
  - pmem strobe high from cycle N+1.
  - resp_x in the cycle pmem_resp arrives.
  - Minimum is 2 cycles, request to resp, when pmem_resp arrives in the first SERVE cycle.
- Every transaction is followed by exactly one IDLE cycle, so there is one arbitration bubble between back-to-back transactions.
- pmem_* outputs are registered, so they are glitch-free and constant throughout SERVE_x.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN:
  - Defined: a 1-bit last_grant register, reset to A. On a simultaneous request in IDLE, the port not granted last wins. last_grant updates on each grant.
  - Undefined: fixed priority, Port B always beats Port A. The data stage stalls the whole pipeline, so it goes first. The last_grant register is not present.

## Test plan
- Reset mid-write (write_b=1, address_b=0x2000, pmem_resp withheld) → IDLE; pmem_write=0 the cycle after reset asserts. A late pmem_resp produces no resp_b.
- Isolated Port A read, address_a=0x0040, pmem returns 0x1234 after 3 cycles → pmem_read=1 with pmem_address=0x0040 for 3 cycles. Then resp_a=1 with rdata_a=0x1234 for exactly one cycle; resp_b stays 0 throughout.
- Port B byte write, address_b=0x3001, wdata_b=0xAB00, wmask_b=2'b10 → pmem_write=1, pmem_wmask=2'b10, pmem_wdata=0xAB00 until pmem_resp. Then resp_b pulses; pmem_read is never asserted.
- Simultaneous read_a and read_b, macro undefined → B served first. After resp_b, one IDLE cycle, then A is served. Repeating the contention 3 times gives B first every time.
- Simultaneous read_a and read_b held continuously, MEM_ARB_ROUND_ROBIN_EN defined → grants alternate B, A, B, A, with the first grant to B because last_grant resets to A.
- read_a dropped during SERVE_A → the transaction still completes and resp_a pulses once. The next IDLE with no requests leaves pmem_read=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundles the two requester ports (A: instruction fetch,
//               B: data) and the single physical memory port seen by
//               mem_arbiter.
//               slave  = the arbiter's view
//               master = the surrounding environment's view
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if;

  // Port A: read-only instruction fetch
  logic        read_a;
  logic [15:0] address_a;
  logic        resp_a;
  logic [15:0] rdata_a;

  // Port B: read/write data port
  logic        read_b;
  logic        write_b;
  logic [1:0]  wmask_b;
  logic [15:0] address_b;
  logic [15:0] wdata_b;
  logic        resp_b;
  logic [15:0] rdata_b;

  // Physical memory port
  logic        pmem_read;
  logic        pmem_write;
  logic [1:0]  pmem_wmask;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic        pmem_resp;
  logic [15:0] pmem_rdata;

  modport slave (
    input  read_a, address_a,
    input  read_b, write_b, wmask_b, address_b, wdata_b,
    input  pmem_resp, pmem_rdata,
    output resp_a, rdata_a,
    output resp_b, rdata_b,
    output pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata
  );

  modport master (
    output read_a, address_a,
    output read_b, write_b, wmask_b, address_b, wdata_b,
    output pmem_resp, pmem_rdata,
    input  resp_a, rdata_a,
    input  resp_b, rdata_b,
    input  pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Serialises the LC-3b pipeline's fetch port (A) and data
//               port (B) onto one physical memory port. One transaction is
//               outstanding at a time; every transaction is followed by a
//               single IDLE arbitration cycle.
// Config      : MEM_ARB_ROUND_ROBIN_EN - when defined, simultaneous
//               requests alternate between ports; otherwise port B always
//               wins a tie.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter (
  input  wire            clk,
  input  wire            reset,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_A = 2'd1,
    ST_SERVE_B = 2'd2
  } state_t;

  state_t      state_q,      state_d;
  logic        pmem_read_q,  pmem_read_d;
  logic        pmem_write_q, pmem_write_d;
  logic [1:0]  wmask_q,      wmask_d;
  logic [15:0] address_q,    address_d;
  logic [15:0] wdata_q,      wdata_d;

  logic        req_a;
  logic        req_b;
  logic        grant_a;
  logic        grant_b;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 0 = port A was granted last, 1 = port B was granted last
  logic        last_grant_q, last_grant_d;
`endif

  assign req_a = bus.read_a;
  assign req_b = bus.read_b | bus.write_b;

  // Tie-break between the two ports; only meaningful while in IDLE
  always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie the port that was not granted last wins
    grant_b = req_b & (~req_a | ~last_grant_q);
`else
    // The data stage stalls the whole pipeline, so it always goes first
    grant_b = req_b;
`endif
    grant_a = req_a & ~grant_b;
  end

  // Next-state and captured-transaction logic
  always_comb begin
    state_d      = state_q;
    pmem_read_d  = pmem_read_q;
    pmem_write_d = pmem_write_q;
    wmask_d      = wmask_q;
    address_d    = address_q;
    wdata_d      = wdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // pmem_resp here belongs to nobody and is ignored
        if (grant_b) begin
          state_d      = ST_SERVE_B;
          // read_b together with write_b is illegal; treat it as a write
          pmem_write_d = bus.write_b;
          pmem_read_d  = ~bus.write_b;
          wmask_d      = bus.wmask_b;
          address_d    = bus.address_b;
          wdata_d      = bus.wdata_b;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = 1'b1;
`endif
        end else if (grant_a) begin
          state_d      = ST_SERVE_A;
          pmem_write_d = 1'b0;
          pmem_read_d  = 1'b1;
          wmask_d      = 2'b11;
          address_d    = bus.address_a;
          wdata_d      = 16'h0000;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = 1'b0;
`endif
        end
      end

      ST_SERVE_A, ST_SERVE_B: begin
        // Requests are not re-examined here: a dropped request still
        // completes. Address/data/mask are left as captured.
        if (bus.pmem_resp) begin
          state_d      = ST_IDLE;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
      end
    endcase
  end

  // State and registered physical-port outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      wmask_q      <= 2'b00;
      address_q    <= 16'h0000;
      wdata_q      <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
      wmask_q      <= wmask_d;
      address_q    <= address_d;
      wdata_q      <= wdata_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Grant history for the round-robin tie-break; resets to "A last"
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Physical port driven straight from registers so it is glitch-free
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_wmask   = wmask_q;
  assign bus.pmem_address = address_q;
  assign bus.pmem_wdata   = wdata_q;

  // Completion pulses are combinational so resp lands in the pmem_resp cycle
  assign bus.resp_a  = (state_q == ST_SERVE_A) & bus.pmem_resp;
  assign bus.resp_b  = (state_q == ST_SERVE_B) & bus.pmem_resp;

  // Read data is shared; only the resp pulse qualifies it
  assign bus.rdata_a = bus.pmem_rdata;
  assign bus.rdata_b = bus.pmem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: a directed vector
//               table plus hand-written multi-cycle sequences (drop during
//               service, contention ordering, reset mid-write).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic clk;
  logic reset;

  mem_arbiter_if bus ();

  mem_arbiter u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        ra;
    logic [15:0] aa;
    logic        rb;
    logic        wb;
    logic [1:0]  mb;
    logic [15:0] ab;
    logic [15:0] db;
    logic        presp;
    logic [15:0] prdata;
    logic        e_rd;
    logic        e_wr;
    logic        e_bus;   // check mask/address/wdata on this row
    logic [1:0]  e_mask;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_ra;
    logic        e_rb;
    logic [15:0] e_rdata;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Wait (bounded) for a physical strobe; n = negedges waited
  task automatic wait_strobe(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 8) begin
      @(negedge clk);
      n++;
      if (bus.pmem_read || bus.pmem_write) ok = 1'b1;
    end
    chk("strobe_seen", {31'd0, ok}, 32'd1);
  endtask

  // One transaction: expect a grant to the given port, respond in the
  // second serve cycle, optionally drop the served request, check bubble.
  task automatic serve(input logic [15:0] exp_addr, input bit exp_b,
                       input logic [15:0] rd, input bit drop, input bit imm);
    bit ok;
    int n;
    wait_strobe(ok, n);
    if (imm) chk("one_bubble", n, 32'd1);
    chk("grant_addr", {16'd0, bus.pmem_address}, {16'd0, exp_addr});
    @(posedge clk); #1;
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = rd;
    @(negedge clk);
    chk("serve_resp_a", {31'd0, bus.resp_a}, {31'd0, ~exp_b});
    chk("serve_resp_b", {31'd0, bus.resp_b}, {31'd0, exp_b});
    chk("serve_rdata", {16'd0, exp_b ? bus.rdata_b : bus.rdata_a}, {16'd0, rd});
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    if (drop) begin
      if (exp_b) bus.read_b = 1'b0;
      else       bus.read_a = 1'b0;
    end
    @(negedge clk);
    chk("bubble_idle", {31'd0, bus.pmem_read | bus.pmem_write}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    logic [15:0] exp_seq [4];

    //            ra  aa       rb  wb  mb     ab       db       pr  prd       rd  wr  bus mask   addr     wdata    ra  rb  rdata
    vecs[0]  = '{1'b1,16'h0040,1'b0,1'b0,2'b00,16'h0000,16'h0000,1'b0,16'h0000, 1'b0,1'b0,1'b1,2'b00,16'h0000,16'h0000,1'b0,1'b0,16'h0000};
    vecs[1]  = '{1'b1,16'h0040,1'b0,1'b0,2'b00,16'h0000,16'h0000,1'b0,16'h0000, 1'b1,1'b0,1'b1,2'b11,16'h0040,16'h0000,1'b0,1'b0,16'h0000};
    vecs[2]  = '{1'b1,16'h0040,1'b0,1'b0,2'b00,16'h0000,16'h0000,1'b0,16'h0000, 1'b1,1'b0,1'b1,2'b11,16'h0040,16'h0000,1'b0,1'b0,16'h0000};
    vecs[3]  = '{1'b1,16'h0040,1'b0,1'b0,2'b00,16'h0000,16'h0000,1'b1,16'h1234, 1'b1,1'b0,1'b1,2'b11,16'h0040,16'h0000,1'b1,1'b0,16'h1234};
    vecs[4]  = '{1'b0,16'h0000,1'b0,1'b0,2'b00,16'h0000,16'h0000,1'b0,16'h0000, 1'b0,1'b0,1'b0,2'b00,16'h0000,16'h0000,1'b0,1'b0,16'h0000};
    vecs[5]  = '{1'b0,16'h0000,1'b0,1'b1,2'b10,16'h3001,16'hAB00,1'b0,16'h0000, 1'b0,1'b0,1'b0,2'b00,16'h0000,16'h0000,1'b0,1'b0,16'h0000};
    vecs[6]  = '{1'b0,16'h0000,1'b0,1'b1,2'b10,16'h3001,16'hAB00,1'b0,16'h0000, 1'b0,1'b1,1'b1,2'b10,16'h3001,16'hAB00,1'b0,1'b0,16'h0000};
    vecs[7]  = '{1'b0,16'h0000,1'b0,1'b1,2'b10,16'h3001,16'hAB00,1'b1,16'h5555, 1'b0,1'b1,1'b1,2'b10,16'h3001,16'hAB00,1'b0,1'b1,16'h5555};
    vecs[8]  = '{1'b0,16'h0000,1'b0,1'b0,2'b00,16'h0000,16'h0000,1'b1,16'h9999, 1'b0,1'b0,1'b0,2'b00,16'h0000,16'h0000,1'b0,1'b0,16'h0000};
    vecs[9]  = '{1'b0,16'h0000,1'b1,1'b1,2'b01,16'h0500,16'h00CD,1'b0,16'h0000, 1'b0,1'b0,1'b0,2'b00,16'h0000,16'h0000,1'b0,1'b0,16'h0000};
    vecs[10] = '{1'b0,16'h0000,1'b1,1'b1,2'b01,16'h0500,16'h00CD,1'b1,16'h4242, 1'b0,1'b1,1'b1,2'b01,16'h0500,16'h00CD,1'b0,1'b1,16'h4242};
    vecs[11] = '{1'b0,16'h0000,1'b0,1'b0,2'b00,16'h0000,16'h0000,1'b0,16'h0000, 1'b0,1'b0,1'b0,2'b00,16'h0000,16'h0000,1'b0,1'b0,16'h0000};
    vecs[12] = '{1'b1,16'hBEEF,1'b0,1'b0,2'b00,16'h1111,16'hFFFF,1'b0,16'h0000, 1'b0,1'b0,1'b0,2'b00,16'h0000,16'h0000,1'b0,1'b0,16'h0000};
    vecs[13] = '{1'b1,16'hBEEF,1'b0,1'b0,2'b00,16'h1111,16'hFFFF,1'b1,16'hCAFE, 1'b1,1'b0,1'b1,2'b11,16'hBEEF,16'h0000,1'b1,1'b0,16'hCAFE};
    vecs[14] = '{1'b0,16'h0000,1'b0,1'b0,2'b00,16'h0000,16'h0000,1'b0,16'h0000, 1'b0,1'b0,1'b0,2'b00,16'h0000,16'h0000,1'b0,1'b0,16'h0000};

    reset          = 1'b1;
    bus.read_a     = 1'b0;
    bus.address_a  = 16'h0000;
    bus.read_b     = 1'b0;
    bus.write_b    = 1'b0;
    bus.wmask_b    = 2'b00;
    bus.address_b  = 16'h0000;
    bus.wdata_b    = 16'h0000;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = 16'h0000;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_pmem_read",  {31'd0, bus.pmem_read},     32'd0);
    chk("rst_pmem_write", {31'd0, bus.pmem_write},    32'd0);
    chk("rst_pmem_wmask", {30'd0, bus.pmem_wmask},    32'd0);
    chk("rst_pmem_addr",  {16'd0, bus.pmem_address},  32'd0);
    chk("rst_pmem_wdata", {16'd0, bus.pmem_wdata},    32'd0);
    chk("rst_resp_a",     {31'd0, bus.resp_a},        32'd0);
    chk("rst_resp_b",     {31'd0, bus.resp_b},        32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed vector table, one row per cycle
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk); #1;
      bus.read_a     = vecs[i].ra;
      bus.address_a  = vecs[i].aa;
      bus.read_b     = vecs[i].rb;
      bus.write_b    = vecs[i].wb;
      bus.wmask_b    = vecs[i].mb;
      bus.address_b  = vecs[i].ab;
      bus.wdata_b    = vecs[i].db;
      bus.pmem_resp  = vecs[i].presp;
      bus.pmem_rdata = vecs[i].prdata;
      @(negedge clk);
      chk($sformatf("v%0d_pmem_read", i),  {31'd0, bus.pmem_read},  {31'd0, vecs[i].e_rd});
      chk($sformatf("v%0d_pmem_write", i), {31'd0, bus.pmem_write}, {31'd0, vecs[i].e_wr});
      chk($sformatf("v%0d_resp_a", i),     {31'd0, bus.resp_a},     {31'd0, vecs[i].e_ra});
      chk($sformatf("v%0d_resp_b", i),     {31'd0, bus.resp_b},     {31'd0, vecs[i].e_rb});
      if (vecs[i].e_bus) begin
        chk($sformatf("v%0d_wmask", i), {30'd0, bus.pmem_wmask},   {30'd0, vecs[i].e_mask});
        chk($sformatf("v%0d_addr", i),  {16'd0, bus.pmem_address}, {16'd0, vecs[i].e_addr});
        chk($sformatf("v%0d_wdata", i), {16'd0, bus.pmem_wdata},   {16'd0, vecs[i].e_wdata});
      end
      if (vecs[i].e_ra) chk($sformatf("v%0d_rdata_a", i), {16'd0, bus.rdata_a}, {16'd0, vecs[i].e_rdata});
      if (vecs[i].e_rb) chk($sformatf("v%0d_rdata_b", i), {16'd0, bus.rdata_b}, {16'd0, vecs[i].e_rdata});
    end

    // read_a dropped during SERVE_A still completes
    @(posedge clk); #1;
    bus.read_a    = 1'b1;
    bus.address_a = 16'h0777;
    wait_strobe(ok, n);
    chk("drop_pmem_read", {31'd0, bus.pmem_read},     32'd1);
    chk("drop_addr",      {16'd0, bus.pmem_address},  32'h0777);
    @(posedge clk); #1;
    bus.read_a = 1'b0;
    @(negedge clk);
    chk("drop_held", {31'd0, bus.pmem_read}, 32'd1);
    @(posedge clk); #1;
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = 16'h7777;
    @(negedge clk);
    chk("drop_resp_a",  {31'd0, bus.resp_a},  32'd1);
    chk("drop_resp_b",  {31'd0, bus.resp_b},  32'd0);
    chk("drop_rdata_a", {16'd0, bus.rdata_a}, 32'h7777);
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    @(negedge clk);
    chk("drop_resp_once", {31'd0, bus.resp_a},    32'd0);
    chk("drop_idle_rd",   {31'd0, bus.pmem_read}, 32'd0);
    @(negedge clk);
    chk("drop_idle_rd2",  {31'd0, bus.pmem_read}, 32'd0);

    // Contention with requesters dropping after service: B first every round
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      bus.read_a    = 1'b1;
      bus.address_a = 16'h0A0A;
      bus.read_b    = 1'b1;
      bus.address_b = 16'h0B0B;
      serve(16'h0B0B, 1'b1, 16'h1B00 + 16'(r), 1'b1, 1'b0);
      serve(16'h0A0A, 1'b0, 16'h1A00 + 16'(r), 1'b1, 1'b1);
    end

    // Both held continuously
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq[0] = 16'h0B0B; exp_seq[1] = 16'h0A0A;
    exp_seq[2] = 16'h0B0B; exp_seq[3] = 16'h0A0A;
`else
    exp_seq[0] = 16'h0B0B; exp_seq[1] = 16'h0B0B;
    exp_seq[2] = 16'h0B0B; exp_seq[3] = 16'h0B0B;
`endif
    @(posedge clk); #1;
    bus.read_a = 1'b1;
    bus.read_b = 1'b1;
    for (int g = 0; g < 4; g++) begin
      serve(exp_seq[g], exp_seq[g] == 16'h0B0B, 16'h2000 + 16'(g), 1'b0, g != 0);
      if (g == 3) begin
        bus.read_a = 1'b0;
        bus.read_b = 1'b0;
      end
    end
    @(negedge clk);
    chk("cont_quiet", {31'd0, bus.pmem_read | bus.pmem_write}, 32'd0);

    // Reset in the middle of a Port B write
    @(posedge clk); #1;
    bus.write_b   = 1'b1;
    bus.address_b = 16'h2000;
    bus.wdata_b   = 16'h1111;
    bus.wmask_b   = 2'b11;
    wait_strobe(ok, n);
    chk("rstw_write", {31'd0, bus.pmem_write},    32'd1);
    chk("rstw_addr",  {16'd0, bus.pmem_address},  32'h2000);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rstw_write_clr", {31'd0, bus.pmem_write},   32'd0);
    @(negedge clk);
    chk("rstw_addr_clr",  {16'd0, bus.pmem_address}, 32'd0);
    @(posedge clk); #1;
    bus.write_b = 1'b0;
    @(posedge clk); #1;
    reset         = 1'b0;
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    chk("rstw_late_resp_b", {31'd0, bus.resp_b},     32'd0);
    chk("rstw_late_write",  {31'd0, bus.pmem_write}, 32'd0);
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    @(negedge clk);
    chk("rstw_still_idle", {31'd0, bus.pmem_write | bus.pmem_read}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
